ahb_sram_slave: RTL and testbench



---
 rtl/ahb_pkg.sv | 20 ++
 rtl/ahb_sram_slave_mem.sv | 30 +++
 rtl/ahb_sram_slave.sv | 87 ++++++++
 tb/tb_ahb_sram_slave.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB bus encodings plus the SRAM slave state type and byte-enable helper.
package ahb_pkg;
  typedef enum logic [1:0] {HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ} type_htrans;
  typedef enum logic [2:0] {
    HBURST_SINGLE, HBURST_INCR, HBURST_WRAP4, HBURST_INCR4,
    HBURST_WRAP8, HBURST_INCR8, HBURST_WRAP16, HBURST_INCR16
  } type_hburst;
  typedef enum logic [2:0] {
    HSIZE_BYTE, HSIZE_HALF, HSIZE_WORD, HSIZE_DWORD,
    HSIZE_4WORD, HSIZE_8WORD, HSIZE_16WORD, HSIZE_32WORD
  } type_hsize;
  typedef enum logic [1:0] {HRESP_OKAY, HRESP_ERROR, HRESP_RETRY, HRESP_SPLIT} type_hresp;
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DONE, ST_ERR1, ST_ERR2} type_slv_state;

  // Little-endian lanes; callers reject misaligned or oversized transfers beforehand.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lane);
    return size == HSIZE_BYTE ? 4'b0001 << lane :
           size == HSIZE_HALF ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/ahb_sram_slave_mem.sv
// ahb_sram_slave_mem: word RAM with byte-write enables and a registered, write-first read port.
module ahb_sram_slave_mem #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [31:0]              rdata
);
  logic [31:0] ram [DEPTH];
  logic [31:0] rdata_q, rdata_d;
  // A read of the word being written this edge returns the merged new bytes.
  always_comb begin
    rdata_d = rdata_q;
    for (int i = 0; i < 4; i++)
      if (re) rdata_d[8*i +: 8] = (we && be[i] && waddr == raddr) ? wdata[8*i +: 8] : ram[raddr][8*i +: 8];
  end
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we && be[i]) ram[waddr][8*i +: 8] <= wdata[8*i +: 8];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata_q <= '0;
    else rdata_q <= rdata_d;
  assign rdata = rdata_q;
endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB responder over a word RAM with wait states, byte writes and two-cycle ERROR.
// Define AHB_SRAM_SLAVE_RO_EN to reject writes at offsets >= RO_BASE.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int REGION_AW   = 16,
  parameter int WAIT_STATES = 0,
  parameter int RO_BASE     = 'h8000
) (
  input  logic        HCLK,
  input  logic        HRESETN,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic [3:0]  HMASTER,
  input  logic        HMASTLOCK,
  input  logic        HREADY_IN,
  output logic        HREADY,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA,
  output logic [15:0] HSPLIT
);
  localparam int AW = $clog2(DEPTH);
  type_slv_state state_q, state_d;
  logic [3:0]    cnt_q, cnt_d, be_q, be_d;
  logic [AW-1:0] idx_q, idx_d, idx_a, raddr;
  logic          write_q, write_d, hready_q, hready_d;
  logic [1:0]    hresp_q, hresp_d;
  logic [31:0]   off;
  logic          accept, err, ro_err, re, we, unused_ok;
  assign off   = 32'(HADDR[REGION_AW-1:0]);
  assign idx_a = HADDR[AW+1:2];
`ifdef AHB_SRAM_SLAVE_RO_EN
  assign ro_err = HWRITE && off >= 32'(RO_BASE);
`else
  assign ro_err = 1'b0;
`endif
  assign accept = HSEL && HREADY_IN && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign err = off >= 32'(DEPTH * 4) || HSIZE > HSIZE_WORD || (HSIZE == HSIZE_HALF && HADDR[0])
            || (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00) || ro_err;
  always_comb begin
    state_d  = state_q == ST_WAIT ? (cnt_q == 4'd0 ? ST_DONE : ST_WAIT) :
               state_q == ST_ERR1 ? ST_ERR2 :
               !accept ? ST_IDLE : err ? ST_ERR1 : WAIT_STATES == 0 ? ST_DONE : ST_WAIT;
    cnt_d    = state_q == ST_WAIT ? cnt_q - 4'd1 : 4'(WAIT_STATES - 1);
    idx_d    = accept ? idx_a : idx_q;
    be_d     = accept ? byte_en(HSIZE, HADDR[1:0]) : be_q;
    write_d  = accept ? HWRITE : write_q;
    hready_d = !(state_d == ST_WAIT || state_d == ST_ERR1);
    hresp_d  = (state_d == ST_ERR1 || state_d == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  end
  always_ff @(posedge HCLK or negedge HRESETN)
    if (!HRESETN) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      be_q     <= '0;
      write_q  <= 1'b0;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      be_q     <= be_d;
      write_q  <= write_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
    end
  // Read at acceptance with no wait states, otherwise on the last wait edge.
  assign we    = state_q == ST_DONE && write_q;
  assign re    = state_q == ST_WAIT ? (cnt_q == 4'd0 && !write_q) : (accept && !HWRITE && !err && WAIT_STATES == 0);
  assign raddr = state_q == ST_WAIT ? idx_q : idx_a;
  ahb_sram_slave_mem #(.DEPTH(DEPTH)) u_mem (
    .clk(HCLK), .rst_n(HRESETN), .we(we), .be(be_q), .waddr(idx_q), .wdata(HWDATA),
    .re(re), .raddr(raddr), .rdata(HRDATA)
  );
  assign HREADY    = hready_q;
  assign HRESP     = hresp_q;
  assign HSPLIT    = '0;
  assign unused_ok = ^{HBURST, HMASTER, HMASTLOCK, HADDR[31:REGION_AW]};
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed checks on three slave instances (0 waits, 2 waits, 64 KB array).
module tb_ahb_sram_slave;
  import ahb_pkg::*;
  localparam logic [2:0] S0 = 3'b100, S2 = 3'b010, SB = 3'b001;
  logic clk = 1'b0, hresetn = 1'b0;
  logic sel0 = 1'b0, sel2 = 1'b0, selb = 1'b0, hwrite = 1'b0;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [1:0] htrans = '0;
  logic [2:0] hsize = '0;
  logic r0, r2, rb;
  logic [1:0] p0, p2, pb;
  logic [31:0] d0, d2, db;
  logic [15:0] s0, s2, sb;
  int vecs = 0, errs = 0;

  always #5 clk = ~clk;

  ahb_sram_slave #(.WAIT_STATES(0)) u0 (
    .HCLK(clk), .HRESETN(hresetn), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(3'b000), .HWDATA(hwdata), .HMASTER(4'h0), .HMASTLOCK(1'b0),
    .HREADY_IN(r0), .HREADY(r0), .HRESP(p0), .HRDATA(d0), .HSPLIT(s0));
  ahb_sram_slave #(.WAIT_STATES(2)) u2 (
    .HCLK(clk), .HRESETN(hresetn), .HSEL(sel2), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(3'b000), .HWDATA(hwdata), .HMASTER(4'h0), .HMASTLOCK(1'b0),
    .HREADY_IN(r2), .HREADY(r2), .HRESP(p2), .HRDATA(d2), .HSPLIT(s2));
  ahb_sram_slave #(.DEPTH(16384), .WAIT_STATES(0)) ub (
    .HCLK(clk), .HRESETN(hresetn), .HSEL(selb), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(3'b000), .HWDATA(hwdata), .HMASTER(4'h0), .HMASTLOCK(1'b0),
    .HREADY_IN(rb), .HREADY(rb), .HRESP(pb), .HRDATA(db), .HSPLIT(sb));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ap(input logic [2:0] s, input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [1:0] t);
    {sel0, sel2, selb} = s;
    haddr = a;
    hwrite = w;
    hsize = sz;
    htrans = t;
  endtask

  task automatic idle();
    {sel0, sel2, selb} = 3'b000;
    htrans = HTRANS_IDLE;
  endtask

  task automatic test_reset();
    cyc(); cyc();
    vecs++; if ({r0, r2, rb} !== 3'b111) begin errs++; $display("FAIL rst_hready got %b exp 111", {r0, r2, rb}); end
    vecs++; if ({p0, p2, pb} !== 6'b0) begin errs++; $display("FAIL rst_hresp got %b exp 000000", {p0, p2, pb}); end
    vecs++; if ({d0, d2, db} !== 96'b0) begin errs++; $display("FAIL rst_hrdata got %h exp 0", {d0, d2, db}); end
    vecs++; if ({s0, s2, sb} !== 48'b0) begin errs++; $display("FAIL rst_hsplit got %h exp 0", {s0, s2, sb}); end
    hresetn = 1'b1;
    cyc();
  endtask

  task automatic test_write_read();
    ap(S0, 32'h10, 1'b1, HSIZE_WORD, HTRANS_NONSEQ); cyc();
    hwdata = 32'hDEADBEEF; idle();
    vecs++; if (r0 !== 1'b1 || p0 !== HRESP_OKAY) begin errs++; $display("FAIL wr_resp got %b/%0d exp 1/0", r0, p0); end
    cyc();
    ap(S0, 32'h10, 1'b0, HSIZE_WORD, HTRANS_NONSEQ); cyc(); idle();
    vecs++; if (r0 !== 1'b1 || p0 !== HRESP_OKAY) begin errs++; $display("FAIL rd_resp got %b/%0d exp 1/0", r0, p0); end
    vecs++; if (d0 !== 32'hDEADBEEF) begin errs++; $display("FAIL rd_data got %h exp deadbeef", d0); end
    cyc();
  endtask

  task automatic test_wait_states();
    int low;
    ap(S2, 32'h0, 1'b1, HSIZE_WORD, HTRANS_NONSEQ); cyc();
    hwdata = 32'h12345678; idle();
    low = 0;
    for (int i = 0; i < 6 && r2 === 1'b0; i++) begin low++; cyc(); end
    vecs++; if (low !== 2 || p2 !== HRESP_OKAY) begin errs++; $display("FAIL ws_write low=%0d resp=%0d exp 2/0", low, p2); end
    cyc();
    ap(S2, 32'h0, 1'b0, HSIZE_WORD, HTRANS_NONSEQ); cyc(); idle();
    low = 0;
    for (int i = 0; i < 6 && r2 === 1'b0; i++) begin low++; cyc(); end
    vecs++; if (low !== 2) begin errs++; $display("FAIL ws_read_low got %0d exp 2", low); end
    vecs++; if (r2 !== 1'b1 || p2 !== HRESP_OKAY) begin errs++; $display("FAIL ws_read_resp got %b/%0d exp 1/0", r2, p2); end
    vecs++; if (d2 !== 32'h12345678) begin errs++; $display("FAIL ws_read_data got %h exp 12345678", d2); end
    cyc();
  endtask

  task automatic test_byte_lanes();
    ap(S0, 32'h20, 1'b1, HSIZE_WORD, HTRANS_NONSEQ); cyc();
    hwdata = 32'h11223344; ap(S0, 32'h21, 1'b1, HSIZE_BYTE, HTRANS_NONSEQ); cyc();
    hwdata = 32'h5555AA55; ap(S0, 32'h20, 1'b0, HSIZE_WORD, HTRANS_NONSEQ); cyc(); idle();
    vecs++; if (r0 !== 1'b1 || d0 !== 32'h1122AA44) begin errs++; $display("FAIL fwd_byte got %b/%h exp 1/1122aa44", r0, d0); end
    cyc();
    ap(S0, 32'h22, 1'b1, HSIZE_HALF, HTRANS_NONSEQ); cyc();
    hwdata = 32'hBEEF7777; ap(S0, 32'h20, 1'b0, HSIZE_WORD, HTRANS_NONSEQ); cyc(); idle();
    vecs++; if (d0 !== 32'hBEEFAA44) begin errs++; $display("FAIL fwd_half got %h exp beefaa44", d0); end
    cyc();
    ap(S0, 32'h20, 1'b0, HSIZE_WORD, HTRANS_NONSEQ); cyc(); idle();
    vecs++; if (d0 !== 32'hBEEFAA44) begin errs++; $display("FAIL ram_lanes got %h exp beefaa44", d0); end
    cyc();
  endtask

  task automatic test_errors();
    logic [31:0] ea [3] = '{32'h1, 32'h0, 32'h2};
    logic [2:0]  es [3] = '{HSIZE_HALF, HSIZE_DWORD, HSIZE_WORD};
    ap(S0, 32'h0, 1'b1, HSIZE_WORD, HTRANS_NONSEQ); cyc();
    hwdata = 32'hCAFEF00D; idle(); cyc();
    ap(S0, 32'h1002, 1'b0, HSIZE_WORD, HTRANS_NONSEQ); cyc(); idle();
    vecs++; if (r0 !== 1'b0 || p0 !== HRESP_ERROR) begin errs++; $display("FAIL misal_err1 got %b/%0d exp 0/1", r0, p0); end
    cyc();
    vecs++; if (r0 !== 1'b1 || p0 !== HRESP_ERROR) begin errs++; $display("FAIL misal_err2 got %b/%0d exp 1/1", r0, p0); end
    cyc();
    vecs++; if (r0 !== 1'b1 || p0 !== HRESP_OKAY) begin errs++; $display("FAIL err_idle got %b/%0d exp 1/0", r0, p0); end
    ap(S0, 32'h1000, 1'b1, HSIZE_WORD, HTRANS_NONSEQ); cyc();
    hwdata = 32'hBAD0BAD0; idle();
    vecs++; if (r0 !== 1'b0 || p0 !== HRESP_ERROR) begin errs++; $display("FAIL oor_err1 got %b/%0d exp 0/1", r0, p0); end
    cyc();
    vecs++; if (r0 !== 1'b1 || p0 !== HRESP_ERROR) begin errs++; $display("FAIL oor_err2 got %b/%0d exp 1/1", r0, p0); end
    cyc();
    for (int i = 0; i < 3; i++) begin
      ap(S0, ea[i], 1'b1, es[i], HTRANS_NONSEQ); cyc();
      hwdata = 32'hFFFFFFFF; idle();
      vecs++; if (r0 !== 1'b0 || p0 !== HRESP_ERROR) begin errs++; $display("FAIL bad_wr%0d got %b/%0d exp 0/1", i, r0, p0); end
      cyc(); cyc();
    end
    ap(S0, 32'h0, 1'b0, HSIZE_WORD, HTRANS_NONSEQ); cyc(); idle();
    vecs++; if (p0 !== HRESP_OKAY || d0 !== 32'hCAFEF00D) begin errs++; $display("FAIL err_noram got %0d/%h exp 0/cafef00d", p0, d0); end
    cyc();
  endtask

  task automatic test_reset_mid();
    ap(S2, 32'h40, 1'b1, HSIZE_WORD, HTRANS_NONSEQ); cyc();
    hwdata = 32'h01020304; idle(); cyc(); cyc(); cyc();
    ap(S2, 32'h40, 1'b1, HSIZE_WORD, HTRANS_NONSEQ); cyc();
    hwdata = 32'hFFFFFFFF; idle();
    vecs++; if (r2 !== 1'b0) begin errs++; $display("FAIL mid_wait got %b exp 0", r2); end
    hresetn = 1'b0; #1;
    vecs++; if (r2 !== 1'b1 || p2 !== HRESP_OKAY || d2 !== 32'h0) begin errs++; $display("FAIL mid_rst got %b/%0d/%h exp 1/0/0", r2, p2, d2); end
    cyc(); hresetn = 1'b1; cyc();
    ap(S2, 32'h40, 1'b0, HSIZE_WORD, HTRANS_NONSEQ); cyc(); idle(); cyc(); cyc();
    vecs++; if (r2 !== 1'b1 || d2 !== 32'h01020304) begin errs++; $display("FAIL mid_keep got %b/%h exp 1/01020304", r2, d2); end
    cyc();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 7; i++) begin
      if (i < 3) ap(SB, 32'h100 + 32'(4 * i), 1'b1, HSIZE_WORD, i == 0 ? HTRANS_NONSEQ : HTRANS_SEQ);
      else if (i < 6) ap(SB, 32'h100 + 32'(4 * (i - 3)), 1'b0, HSIZE_WORD, i == 3 ? HTRANS_NONSEQ : HTRANS_SEQ);
      else idle();
      hwdata = 32'hA0000000 + 32'(i - 1);
      if (i >= 1) begin
        vecs++; if (rb !== 1'b1 || pb !== HRESP_OKAY) begin errs++; $display("FAIL b2b_rdy%0d got %b/%0d exp 1/0", i, rb, pb); end
      end
      if (i >= 4) begin
        vecs++; if (db !== 32'hA0000000 + 32'(i - 4)) begin errs++; $display("FAIL b2b_data%0d got %h exp %h", i, db, 32'hA0000000 + 32'(i - 4)); end
      end
      cyc();
    end
  endtask

  task automatic test_ro();
    ap(SB, 32'h8000, 1'b1, HSIZE_WORD, HTRANS_NONSEQ); cyc();
    hwdata = 32'h5A5A5A5A; idle();
`ifdef AHB_SRAM_SLAVE_RO_EN
    vecs++; if (rb !== 1'b0 || pb !== HRESP_ERROR) begin errs++; $display("FAIL ro_err1 got %b/%0d exp 0/1", rb, pb); end
    cyc();
    vecs++; if (rb !== 1'b1 || pb !== HRESP_ERROR) begin errs++; $display("FAIL ro_err2 got %b/%0d exp 1/1", rb, pb); end
    cyc();
`else
    vecs++; if (rb !== 1'b1 || pb !== HRESP_OKAY) begin errs++; $display("FAIL ro_off_wr got %b/%0d exp 1/0", rb, pb); end
    cyc();
`endif
    ap(SB, 32'h8000, 1'b0, HSIZE_WORD, HTRANS_NONSEQ); cyc(); idle();
    vecs++; if (pb !== HRESP_OKAY) begin errs++; $display("FAIL ro_rd_resp got %0d exp 0", pb); end
`ifdef AHB_SRAM_SLAVE_RO_EN
    vecs++; if (db === 32'h5A5A5A5A) begin errs++; $display("FAIL ro_unchanged got %h exp not 5a5a5a5a", db); end
`else
    vecs++; if (db !== 32'h5A5A5A5A) begin errs++; $display("FAIL ro_off_data got %h exp 5a5a5a5a", db); end
`endif
    cyc();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait_states();
    test_byte_lanes();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_ro();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
